// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: one-outstanding-request fetch FSM feeding a small
// PC/instruction FIFO, with pipeline redirect (flush) support.
module instr_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [2:0]  count
);

    localparam int         PW      = (DEPTH > 2) ? 2 : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   pending_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   redirect_tgt;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign push         = (state == REQ) && mem_ack && !redirect;
    assign pop          = out_valid && out_ready;

    assign mem_req   = (state != IDLE);
    assign mem_addr  = fetch_pc;
    assign out_valid = (count != 3'd0);
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;

    // Fetch FSM: DRAIN keeps the bus request alive but throws its data away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            pending_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect)
                        fetch_pc <= redirect_tgt;
                    else if (count < DEPTH_C)
                        state <= REQ;
                end
                REQ: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        fetch_pc <= redirect ? redirect_tgt : fetch_pc + 32'd4;
                    end else if (redirect) begin
                        state      <= DRAIN;
                        pending_pc <= redirect_tgt;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        fetch_pc <= redirect ? redirect_tgt : pending_pc;
                    end else if (redirect) begin
                        pending_pc <= redirect_tgt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_next(wr_ptr);
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            count <= count + 3'(push) - 3'(pop);
        end
    end

    // Storage needs no reset: out_pc/out_instr are masked by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= mem_rdata;
        end
    end

endmodule
